intt_scheduler: RTL and testbench

Job scheduler that shares one `intt_processor` instance between `NUM_REQ` requesters. It arbitrates round-robin, pulses the processor start and publishes the input beat index for the owner to drive `data_in`. It then watches the output burst, tags every output beat with the owning requester, and signals completion or error. It sits between the requester fabric and the processor; it carries no coefficient data.

---
 rtl/intt_sched_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/intt_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_intt_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/intt_sched_pkg.sv
// rtl/intt_sched_pkg.sv - shared types, error codes and size helpers for intt_scheduler
package intt_sched_pkg;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_GRANT,
        ST_START,
        ST_FEED,
        ST_WAIT,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_SHORT   = 2'd2;
    localparam logic [1:0] ERR_LONG    = 2'd3;

    function automatic int beat_w_f(input int log_n, input int log_core_count);
        return log_n - 2 - log_core_count;
    endfunction

    function automatic int beats_f(input int log_n, input int log_core_count);
        return 1 << beat_w_f(log_n, log_core_count);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting one past the last owner
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  pick,
    output logic          valid
);

    logic [IW-1:0] idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(last) + i) % N);
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intt_scheduler.sv
// rtl/intt_scheduler.sv - round-robin job scheduler sharing one intt_processor among requesters
module intt_scheduler
    import intt_sched_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int LOG_CORE_COUNT = 4,
    parameter  int LOG_N          = 12,
    parameter  int TIMEOUT        = 4096,
    parameter  int FLUSH_CYCLES   = 1024,
    localparam int BEATS          = beats_f(LOG_N, LOG_CORE_COUNT),
    localparam int BEAT_W         = beat_w_f(LOG_N, LOG_CORE_COUNT),
    localparam int OWNER_W        = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               feed_valid,
    output logic [BEAT_W-1:0]  feed_beat,
    output logic               intt_start,
    input  logic               intt_output_active,
    output logic               out_valid,
    output logic [OWNER_W-1:0] out_owner,
    output logic [BEAT_W-1:0]  out_beat,
    output logic [NUM_REQ-1:0] done,
    output logic               error,
    output logic [1:0]         err_code,
    output logic               busy
);

    localparam int CNT_W  = BEAT_W + 1;
    localparam int WD_MAX = (TIMEOUT > FLUSH_CYCLES) ? TIMEOUT : FLUSH_CYCLES;
    localparam int WD_W   = $clog2(WD_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX       = '1;
    localparam logic [CNT_W-1:0]  CNT_BEATS     = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0]  CNT_LAST_FEED = CNT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] BEAT_SAT      = BEAT_W'(BEATS - 1);
    localparam logic [WD_W-1:0]   WD_FLUSH      = WD_W'(FLUSH_CYCLES);
    localparam logic [WD_W-1:0]   WD_LAST       = WD_W'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [OWNER_W-1:0]   last_q, last_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 feed_valid_q, feed_valid_d;
    logic [BEAT_W-1:0]    feed_beat_q, feed_beat_d;
    logic [BEAT_W-1:0]    out_beat_q, out_beat_d;
    logic                 intt_start_q, intt_start_d;
    logic                 error_q, error_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   pick;
    logic                 pick_valid;
    logic [OWNER_W-1:0]   pick_idx;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req),
        .last  (last_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = OWNER_W'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wd_d       = wd_q;
        owner_d    = owner_q;
        last_d     = last_q;
        err_code_d = err_code_q;
        case (state_q)
            // The processor has no reset: wait for FLUSH_CYCLES consecutive quiet cycles.
            ST_FLUSH: begin
                if (intt_output_active) begin
                    wd_d = WD_FLUSH;
                end else if (wd_q <= WD_W'(1)) begin
                    state_d = ST_IDLE;
                    wd_d    = '0;
                end else begin
                    wd_d = wd_q - WD_W'(1);
                end
            end
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d    = ST_GRANT;
                    owner_d    = pick_idx;
                    err_code_d = ERR_OK;
                    cnt_d      = '0;
                end
            end
            ST_GRANT: begin
                state_d = ST_START;
                wd_d    = '0;
            end
            ST_START: begin
                state_d = ST_FEED;
                cnt_d   = '0;
                wd_d    = wd_q + WD_W'(1);
            end
            ST_FEED: begin
                wd_d = wd_q + WD_W'(1);
                if (cnt_q == CNT_LAST_FEED) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // The cycle the burst starts is already beat 0 (see out_valid).
            ST_WAIT: begin
                if (intt_output_active) begin
                    state_d = ST_DRAIN;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (wd_q >= WD_LAST) begin
                    state_d    = ST_DONE;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_DRAIN: begin
                if (intt_output_active) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_DONE;
                    if (cnt_q < CNT_BEATS)      err_code_d = ERR_SHORT;
                    else if (cnt_q > CNT_BEATS) err_code_d = ERR_LONG;
                    else                        err_code_d = ERR_OK;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                last_d  = owner_q;
            end
            default: state_d = ST_FLUSH;
        endcase

        grant_d      = '0;
        done_d       = '0;
        if (state_d != ST_FLUSH && state_d != ST_IDLE) grant_d = NUM_REQ'(1) << owner_d;
        if (state_d == ST_DONE) done_d = NUM_REQ'(1) << owner_d;
        error_d      = (state_d == ST_DONE) && (err_code_d != ERR_OK);
        intt_start_d = (state_d == ST_START);
        feed_valid_d = (state_d == ST_FEED);
        feed_beat_d  = feed_valid_d ? cnt_d[BEAT_W-1:0] : '0;
        busy_d       = (state_d != ST_IDLE);
        out_beat_d   = '0;
        if (state_d == ST_WAIT || state_d == ST_DRAIN || state_d == ST_DONE)
            out_beat_d = (cnt_d >= CNT_BEATS) ? BEAT_SAT : cnt_d[BEAT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FLUSH;
            cnt_q        <= '0;
            wd_q         <= WD_FLUSH;
            owner_q      <= '0;
            last_q       <= OWNER_W'(NUM_REQ - 1);
            err_code_q   <= ERR_OK;
            grant_q      <= '0;
            done_q       <= '0;
            feed_valid_q <= 1'b0;
            feed_beat_q  <= '0;
            out_beat_q   <= '0;
            intt_start_q <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wd_q         <= wd_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            err_code_q   <= err_code_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            feed_valid_q <= feed_valid_d;
            feed_beat_q  <= feed_beat_d;
            out_beat_q   <= out_beat_d;
            intt_start_q <= intt_start_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign feed_valid = feed_valid_q;
    assign feed_beat  = feed_beat_q;
    assign intt_start = intt_start_q;
    assign out_owner  = owner_q;
    assign out_beat   = out_beat_q;
    assign error      = error_q;
    assign err_code   = err_code_q;
    assign busy       = busy_q;
    assign out_valid  = intt_output_active && (state_q == ST_WAIT || state_q == ST_DRAIN);

endmodule

// File: tb/tb_intt_scheduler.sv
// tb/tb_intt_scheduler.sv - randomized self-checking bench for intt_scheduler
module tb_intt_scheduler;

    localparam int NR    = 4;
    localparam int LCC   = 4;
    localparam int LN    = 12;
    localparam int TO    = 200;
    localparam int FC    = 1024;
    localparam int BW    = LN - 2 - LCC;
    localparam int BEATS = 1 << BW;
    localparam int OW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR-1:0] grant;
    logic          feed_valid;
    logic [BW-1:0] feed_beat;
    logic          intt_start;
    logic          intt_output_active;
    logic          out_valid;
    logic [OW-1:0] out_owner;
    logic [BW-1:0] out_beat;
    logic [NR-1:0] done;
    logic          error;
    logic [1:0]    err_code;
    logic          busy;

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int last_m    = NR - 1;
    int prev_done = -1;

    intt_scheduler #(
        .NUM_REQ(NR), .LOG_CORE_COUNT(LCC), .LOG_N(LN), .TIMEOUT(TO), .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant), .feed_valid(feed_valid),
        .feed_beat(feed_beat), .intt_start(intt_start), .intt_output_active(intt_output_active),
        .out_valid(out_valid), .out_owner(out_owner), .out_beat(out_beat), .done(done),
        .error(error), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Rotation rule: first requester found scanning upward from one past the last owner.
    function automatic int rr_model(input logic [NR-1:0] r, input int last);
        for (int i = 1; i <= NR; i++) begin
            if (r[(last + i) % NR]) return (last + i) % NR;
        end
        return -1;
    endfunction

    task automatic flush_watch(input int k, input bit stray);
        int bad;
        bad = 0;
        while (busy !== 1'b0 && cyc < k + FC + 600) begin
            step();
            intt_output_active = stray && (cyc >= k + 300) && (cyc < k + 380);
            #1;
            if (done !== '0 || out_valid !== 1'b0 || grant !== '0 || intt_start !== 1'b0) bad++;
        end
        intt_output_active = 1'b0;
        check_eq("flush_quiet", bad, 0);
        check_eq("flush_idle_cycle", cyc, stray ? k + 380 + FC : k + FC);
    endtask

    task automatic run_job(input logic [NR-1:0] rv, input int len, input int lat,
                           input bit drop, input int rst_at);
        int            exp_o, n, bad, s, d_exp;
        logic [NR-1:0] exp_g;
        logic [1:0]    exp_err;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            step(); #1; n++;
        end
        check_eq("idle_before_job", busy, 0);
        exp_o   = rr_model(rv, last_m);
        exp_g   = NR'(1) << exp_o;
        exp_err = (len == 0) ? 2'd1 : (len < BEATS) ? 2'd2 : (len > BEATS) ? 2'd3 : 2'd0;
        req = rv;
        step(); #1;
        check_eq("grant", grant, exp_g);
        check_eq("err_cleared", err_code, 0);
        if (drop) req = '0;
        step(); #1;
        check_eq("start", intt_start, 1);
        if (prev_done >= 0) check_eq("b2b_gap", cyc - prev_done, 3);
        s   = cyc;
        bad = 0;
        for (int k = 0; k < BEATS; k++) begin
            step(); #1;
            if (feed_valid !== 1'b1 || feed_beat !== BW'(k) || intt_start !== 1'b0 || grant !== exp_g) bad++;
            if (k == rst_at) begin
                check_eq("feed_before_rst", bad, 0);
                rst = 1'b1;
                step(); #1;
                check_eq("rst_grant", grant, 0);
                check_eq("rst_feed", feed_valid, 0);
                check_eq("rst_start", intt_start, 0);
                check_eq("rst_busy", busy, 1);
                rst       = 1'b0;
                prev_done = -1;
                last_m    = NR - 1;
                return;
            end
        end
        check_eq("feed", bad, 0);
        bad   = 0;
        d_exp = s + TO;
        if (len > 0) begin
            for (int i = 0; i < lat; i++) begin
                step(); #1;
                if (out_valid !== 1'b0 || feed_valid !== 1'b0 || done !== '0) bad++;
            end
            for (int k = 0; k < len; k++) begin
                step(); intt_output_active = 1'b1; #1;
                if (out_valid !== 1'b1 || out_owner !== OW'(exp_o) || done !== '0 || feed_valid !== 1'b0 ||
                    out_beat !== BW'((k < BEATS) ? k : BEATS - 1)) bad++;
            end
            step(); intt_output_active = 1'b0; #1;
            if (out_valid !== 1'b0 || done !== '0) bad++;
            d_exp = cyc + 1;
        end
        check_eq("burst", bad, 0);
        n = 0;
        do begin
            step(); #1; n++;
        end while (done === '0 && n < TO + 50);
        check_eq("done_cycle", cyc, d_exp);
        check_eq("done_vec", done, exp_g);
        check_eq("error", error, exp_err != 2'd0);
        check_eq("err_code", err_code, exp_err);
        last_m    = exp_o;
        prev_done = cyc;
        step(); #1;
        check_eq("idle_after", {done, busy}, 0);
        check_eq("err_held", err_code, exp_err);
        req = '0;
    endtask

    initial begin
        int k, sel, len;
        rst = 1'b1;
        req = '0;
        intt_output_active = 1'b0;
        repeat (3) step();
        #1;
        check_eq("rst_grant0", grant, 0);
        check_eq("rst_feed0", {feed_valid, feed_beat}, 0);
        check_eq("rst_start0", intt_start, 0);
        check_eq("rst_out0", {out_valid, out_owner, out_beat}, 0);
        check_eq("rst_done0", {done, error, err_code}, 0);
        check_eq("rst_busy0", busy, 1);
        k   = cyc;
        rst = 1'b0;
        req = 4'b1011;
        flush_watch(k, 1'b0);

        for (int j = 0; j < 5; j++) run_job(4'b1111, BEATS, $urandom_range(0, 10), 1'b0, -1);
        run_job(4'b0001, BEATS, 7, 1'b1, -1);
        run_job(4'b0010, 0, 0, 1'b0, -1);
        run_job(4'b0010, 40, 3, 1'b0, -1);
        run_job(4'b1000, 70, 0, 1'b0, -1);
        run_job(4'b0001, 140, 12, 1'b1, -1);
        run_job(4'b0010, BEATS, 2, 1'b0, -1);
        run_job(4'b0010, BEATS, 2, 1'b0, -1);

        for (int j = 0; j < 12; j++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0:       len = BEATS;
                1:       len = $urandom_range(1, BEATS - 1);
                2:       len = $urandom_range(BEATS + 1, 140);
                3:       len = 0;
                default: len = BEATS;
            endcase
            run_job(NR'($urandom_range(1, 15)), len, $urandom_range(0, 40),
                    1'($urandom_range(0, 1)), -1);
        end

        run_job(4'b0100, BEATS, 0, 1'b0, 20);
        k = cyc;
        flush_watch(k, 1'b1);
        run_job(4'b0100, BEATS, 3, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL sim_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "simulation time limit");
    end

endmodule
